// File: rtl/id_ex_alu_ctrl.sv
// ID/EX boundary register: decodes a MIPS instruction into ALU op, shift amount
// and operand-B select, with hazard-unit stall (hold) and flush (bubble) control.
module id_ex_alu_ctrl #(
    parameter logic [2:0] ILLEGAL_OP = 3'b000,
    parameter logic [2:0] BUBBLE_OP  = 3'b010
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        id_valid,
    input  logic [31:0] id_instr,
    input  logic        stall,
    input  logic        flush,
    output logic        ex_valid,
    output logic [2:0]  ex_alu_op,
    output logic [4:0]  ex_shamt,
    output logic        ex_alu_src_imm,
    output logic [31:0] ex_imm,
    output logic        ex_is_branch,
    output logic        ex_illegal
);
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;
    localparam logic [2:0] ALU_SLL = 3'b100;
    localparam logic [2:0] ALU_SRL = 3'b101;

    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [31:0] imm_sext;
    logic [31:0] imm_zext;
    logic        unused_instr_bits;

    assign opcode   = id_instr[31:26];
    assign funct    = id_instr[5:0];
    assign imm_sext = {{16{id_instr[15]}}, id_instr[15:0]};
    assign imm_zext = {16'h0000, id_instr[15:0]};
    // Register specifiers are consumed elsewhere in the pipeline.
    assign unused_instr_bits = ^id_instr[25:16];

    logic [2:0]  dec_op;
    logic [4:0]  dec_shamt;
    logic        dec_src_imm;
    logic [31:0] dec_imm;
    logic        dec_branch;
    logic        dec_illegal;

    always_comb begin
        dec_op      = ILLEGAL_OP;
        dec_shamt   = 5'd0;
        dec_src_imm = 1'b0;
        dec_imm     = 32'd0;
        dec_branch  = 1'b0;
        dec_illegal = 1'b0;
        unique case (opcode)
            6'b000000: begin
                unique case (funct)
                    6'b100000, 6'b100001: dec_op = ALU_ADD;
                    6'b100010, 6'b100011: dec_op = ALU_SUB;
                    6'b100100:            dec_op = ALU_AND;
                    6'b100101:            dec_op = ALU_OR;
                    6'b101010:            dec_op = ALU_SLT;
                    6'b000000: begin
                        dec_op    = ALU_SLL;
                        dec_shamt = id_instr[10:6];
                    end
                    6'b000010: begin
                        dec_op    = ALU_SRL;
                        dec_shamt = id_instr[10:6];
                    end
                    default:              dec_illegal = 1'b1;
                endcase
            end
            6'b100011, 6'b101011, 6'b001000: begin
                dec_op      = ALU_ADD;
                dec_src_imm = 1'b1;
                dec_imm     = imm_sext;
            end
            6'b001010: begin
                dec_op      = ALU_SLT;
                dec_src_imm = 1'b1;
                dec_imm     = imm_sext;
            end
            6'b001100: begin
                dec_op      = ALU_AND;
                dec_src_imm = 1'b1;
                dec_imm     = imm_zext;
            end
            6'b001101: begin
                dec_op      = ALU_OR;
                dec_src_imm = 1'b1;
                dec_imm     = imm_zext;
            end
            6'b000100: begin
                dec_op     = ALU_SUB;
                dec_imm    = imm_sext;
                dec_branch = 1'b1;
            end
            default: dec_illegal = 1'b1;
        endcase
    end

    logic        valid_q,   valid_d;
    logic [2:0]  alu_op_q,  alu_op_d;
    logic [4:0]  shamt_q,   shamt_d;
    logic        src_imm_q, src_imm_d;
    logic [31:0] imm_q,     imm_d;
    logic        branch_q,  branch_d;
    logic        illegal_q, illegal_d;

    // Flush beats stall; an empty ID slot loads the same bubble as a flush.
    always_comb begin
        valid_d   = valid_q;
        alu_op_d  = alu_op_q;
        shamt_d   = shamt_q;
        src_imm_d = src_imm_q;
        imm_d     = imm_q;
        branch_d  = branch_q;
        illegal_d = illegal_q;
        if (flush || (!stall && !id_valid)) begin
            valid_d   = 1'b0;
            alu_op_d  = BUBBLE_OP;
            shamt_d   = 5'd0;
            src_imm_d = 1'b0;
            imm_d     = 32'd0;
            branch_d  = 1'b0;
            illegal_d = 1'b0;
        end else if (!stall) begin
            valid_d   = 1'b1;
            alu_op_d  = dec_op;
            shamt_d   = dec_shamt;
            src_imm_d = dec_src_imm;
            imm_d     = dec_imm;
            branch_d  = dec_branch;
            illegal_d = dec_illegal;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q   <= 1'b0;
            alu_op_q  <= BUBBLE_OP;
            shamt_q   <= 5'd0;
            src_imm_q <= 1'b0;
            imm_q     <= 32'd0;
            branch_q  <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            valid_q   <= valid_d;
            alu_op_q  <= alu_op_d;
            shamt_q   <= shamt_d;
            src_imm_q <= src_imm_d;
            imm_q     <= imm_d;
            branch_q  <= branch_d;
            illegal_q <= illegal_d;
        end
    end

    assign ex_valid       = valid_q;
    assign ex_alu_op      = alu_op_q;
    assign ex_shamt       = shamt_q;
    assign ex_alu_src_imm = src_imm_q;
    assign ex_imm         = imm_q;
    assign ex_is_branch   = branch_q;
    assign ex_illegal     = illegal_q;
endmodule

// File: tb/tb_id_ex_alu_ctrl.sv
// Bench for id_ex_alu_ctrl: directed vector table followed by randomized
// traffic checked against a behavioural model of the ID/EX register.
module tb_id_ex_alu_ctrl;
    typedef struct packed {
        logic        v;
        logic [2:0]  op;
        logic [4:0]  sh;
        logic        src;
        logic [31:0] imm;
        logic        br;
        logic        ill;
    } exp_t;

    typedef struct packed {
        logic        rst;
        logic        v;
        logic [31:0] instr;
        logic        st;
        logic        fl;
        exp_t        exp;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset, id_valid, stall, flush;
    logic [31:0] id_instr;
    logic        ex_valid, ex_alu_src_imm, ex_is_branch, ex_illegal;
    logic [2:0]  ex_alu_op;
    logic [4:0]  ex_shamt;
    logic [31:0] ex_imm;

    int n_vec  = 0;
    int n_miss = 0;

    id_ex_alu_ctrl dut (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_instr(id_instr),
        .stall(stall), .flush(flush), .ex_valid(ex_valid), .ex_alu_op(ex_alu_op),
        .ex_shamt(ex_shamt), .ex_alu_src_imm(ex_alu_src_imm), .ex_imm(ex_imm),
        .ex_is_branch(ex_is_branch), .ex_illegal(ex_illegal)
    );

    always #5 clk = ~clk;

    localparam exp_t BUBBLE = '{v:1'b0, op:3'b010, sh:5'd0, src:1'b0, imm:32'd0, br:1'b0, ill:1'b0};

    function automatic exp_t mk(logic v, logic [2:0] op, logic [4:0] sh, logic src,
                                logic [31:0] imm, logic br, logic ill);
        exp_t e;
        e = '{v:v, op:op, sh:sh, src:src, imm:imm, br:br, ill:ill};
        return e;
    endfunction

    function automatic vec_t vec(logic rst, logic v, logic [31:0] instr, logic st,
                                 logic fl, exp_t e);
        vec_t x;
        x = '{rst:rst, v:v, instr:instr, st:st, fl:fl, exp:e};
        return x;
    endfunction

    // Decode model, written as a mnemonic lookup straight from the ISA table.
    function automatic exp_t ref_decode(logic [31:0] w);
        string       mn;
        exp_t        e;
        int          opc, fn;
        logic [31:0] s_imm, z_imm;
        opc   = int'(w[31:26]);
        fn    = int'(w[5:0]);
        s_imm = 32'(signed'(w[15:0]));
        z_imm = 32'(w[15:0]);
        mn = "illegal";
        if (opc == 0) begin
            if (fn == 32 || fn == 33) mn = "add";
            else if (fn == 34 || fn == 35) mn = "sub";
            else if (fn == 36) mn = "and";
            else if (fn == 37) mn = "or";
            else if (fn == 42) mn = "slt";
            else if (fn == 0)  mn = "sll";
            else if (fn == 2)  mn = "srl";
        end
        else if (opc == 35 || opc == 43 || opc == 8) mn = "addi";
        else if (opc == 10) mn = "slti";
        else if (opc == 12) mn = "andi";
        else if (opc == 13) mn = "ori";
        else if (opc == 4)  mn = "beq";
        e = mk(1, 3'b000, 0, 0, 0, 0, 0);
        case (mn)
            "add":  e.op = 3'b010;
            "sub":  e.op = 3'b110;
            "and":  e.op = 3'b000;
            "or":   e.op = 3'b001;
            "slt":  e.op = 3'b111;
            "sll":  begin e.op = 3'b100; e.sh = w[10:6]; end
            "srl":  begin e.op = 3'b101; e.sh = w[10:6]; end
            "addi": begin e.op = 3'b010; e.src = 1; e.imm = s_imm; end
            "slti": begin e.op = 3'b111; e.src = 1; e.imm = s_imm; end
            "andi": begin e.op = 3'b000; e.src = 1; e.imm = z_imm; end
            "ori":  begin e.op = 3'b001; e.src = 1; e.imm = z_imm; end
            "beq":  begin e.op = 3'b110; e.br = 1; e.imm = s_imm; end
            default: e.ill = 1;
        endcase
        return e;
    endfunction

    function automatic exp_t got();
        return mk(ex_valid, ex_alu_op, ex_shamt, ex_alu_src_imm, ex_imm, ex_is_branch, ex_illegal);
    endfunction

    task automatic check(string name, exp_t e);
        exp_t g;
        g = got();
        n_vec++;
        if (g !== e) begin
            n_miss++;
            $display("FAIL %s: got v=%b op=%b sh=%0d src=%b imm=%h br=%b ill=%b, want v=%b op=%b sh=%0d src=%b imm=%h br=%b ill=%b",
                     name, g.v, g.op, g.sh, g.src, g.imm, g.br, g.ill,
                     e.v, e.op, e.sh, e.src, e.imm, e.br, e.ill);
        end else begin
            $display("ok   %s: v=%b op=%b sh=%0d src=%b imm=%h br=%b ill=%b",
                     name, g.v, g.op, g.sh, g.src, g.imm, g.br, g.ill);
        end
    endtask

    task automatic drive(logic rst, logic v, logic [31:0] instr, logic st, logic fl);
        reset    = rst;
        id_valid = v;
        id_instr = instr;
        stall    = st;
        flush    = fl;
        @(posedge clk);
        #1;
    endtask

    vec_t vecs[24];
    exp_t model;
    int   opcodes[10] = '{0, 0, 0, 35, 43, 8, 10, 12, 13, 4};
    int   functs[10]  = '{32, 33, 34, 35, 36, 37, 42, 0, 2, 7};

    initial begin
        exp_t lw_e, ori_e;
        lw_e  = mk(1, 3'b010, 0, 1, 32'h4, 0, 0);
        ori_e = mk(1, 3'b001, 0, 1, 32'h0F0F, 0, 0);
        vecs[0]  = vec(1, 1, 32'h00851020, 0, 0, BUBBLE);
        vecs[1]  = vec(1, 1, 32'h00851020, 0, 0, BUBBLE);
        vecs[2]  = vec(0, 1, 32'h00851020, 0, 0, mk(1, 3'b010, 0, 0, 0, 0, 0));
        vecs[3]  = vec(0, 1, 32'h00851022, 0, 0, mk(1, 3'b110, 0, 0, 0, 0, 0));
        vecs[4]  = vec(0, 1, 32'h0085102A, 0, 0, mk(1, 3'b111, 0, 0, 0, 0, 0));
        vecs[5]  = vec(0, 1, 32'h00041082, 0, 0, mk(1, 3'b101, 2, 0, 0, 0, 0));
        vecs[6]  = vec(0, 1, 32'h3082FFFF, 0, 0, mk(1, 3'b000, 0, 1, 32'h0000FFFF, 0, 0));
        vecs[7]  = vec(0, 1, 32'h2082FFFF, 0, 0, mk(1, 3'b010, 0, 1, 32'hFFFFFFFF, 0, 0));
        vecs[8]  = vec(0, 1, 32'h8C820004, 0, 0, lw_e);
        vecs[9]  = vec(0, 1, 32'h00851022, 1, 0, lw_e);
        vecs[10] = vec(0, 1, 32'h3082FFFF, 1, 0, lw_e);
        vecs[11] = vec(0, 0, 32'hFC000000, 1, 0, lw_e);
        vecs[12] = vec(0, 1, 32'h00851022, 1, 1, BUBBLE);
        vecs[13] = vec(0, 1, 32'h10850003, 0, 0, mk(1, 3'b110, 0, 0, 32'h3, 1, 0));
        vecs[14] = vec(0, 1, 32'hFC000000, 0, 0, mk(1, 3'b000, 0, 0, 0, 0, 1));
        vecs[15] = vec(0, 0, 32'hFC000000, 0, 0, BUBBLE);
        vecs[16] = vec(0, 1, 32'h00851560, 0, 0, mk(1, 3'b010, 0, 0, 0, 0, 0));
        vecs[17] = vec(0, 1, 32'h34820F0F, 0, 0, ori_e);
        vecs[18] = vec(0, 1, 32'h00851022, 1, 0, ori_e);
        vecs[19] = vec(1, 1, 32'h00851022, 1, 0, BUBBLE);
        vecs[20] = vec(0, 1, 32'h00851022, 0, 0, mk(1, 3'b110, 0, 0, 0, 0, 0));
        vecs[21] = vec(0, 1, 32'h00000000, 0, 0, mk(1, 3'b100, 0, 0, 0, 0, 0));
        vecs[22] = vec(0, 1, 32'h00851020, 0, 1, BUBBLE);
        vecs[23] = vec(0, 1, 32'h0085103F, 0, 0, mk(1, 3'b000, 0, 0, 0, 0, 1));

        reset = 1; id_valid = 0; id_instr = 0; stall = 0; flush = 0;
        #1;
        for (int i = 0; i < 24; i++) begin
            drive(vecs[i].rst, vecs[i].v, vecs[i].instr, vecs[i].st, vecs[i].fl);
            check($sformatf("vec%0d", i), vecs[i].exp);
        end

        drive(1, 0, 0, 0, 0);
        model = BUBBLE;
        for (int i = 0; i < 400; i++) begin
            logic        r, v, s, f;
            logic [31:0] w;
            w  = $urandom;
            if ($urandom_range(0, 9) != 0) begin
                w[31:26] = 6'(opcodes[$urandom_range(0, 9)]);
                w[5:0]   = 6'(functs[$urandom_range(0, 9)]);
            end
            r = ($urandom_range(0, 29) == 0);
            v = ($urandom_range(0, 4) != 0);
            s = ($urandom_range(0, 3) == 0);
            f = ($urandom_range(0, 7) == 0);
            if (r || f || (!s && !v)) model = BUBBLE;
            else if (!s)              model = ref_decode(w);
            drive(r, v, w, s, f);
            check($sformatf("rnd%0d instr=%h r%b v%b s%b f%b", i, w, r, v, s, f), model);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule

// File: doc/id_ex_alu_ctrl.md
Name: id_ex_alu_ctrl

Overview:
ID-to-EX pipeline stage that decodes a fetched MIPS instruction into the 3-bit ALU operation code, shift amount and operand-B select consumed by the execute-stage ALU. It registers the decoded fields into the ID/EX boundary. It supports pipeline stall (hold) and flush (bubble insertion) from the hazard unit. It is the producer end of the ALU control interface.

Parameters:
ILLEGAL_OP, 3'b000, ALU op driven for undecodable instructions (AND).
BUBBLE_OP, 3'b010, ALU op driven when a bubble is inserted or out of reset (ADD).

Ports:
clk  input  1  pipeline clock, rising-edge.
reset  input  1  synchronous, active-high reset.
id_valid  input  1  ID stage holds a real instruction.
id_instr  input  32  instruction word in ID.
stall  input  1  hold ID/EX contents this cycle.
flush  input  1  load a bubble into ID/EX this cycle.
ex_valid  output  1  EX stage holds a real instruction.
ex_alu_op  output  3  ALU op: 000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT, 100 SLL, 101 SRL.
ex_shamt  output  5  shift amount (instr[10:6] for SLL/SRL, else 0).
ex_alu_src_imm  output  1  1 = operand B is the immediate; 0 = operand B is rt.
ex_imm  output  32  extended immediate.
ex_is_branch  output  1  instruction is BEQ.
ex_illegal  output  1  opcode/funct not decodable.

Behaviour:
- Clock and reset: one clock domain (clk). Reset is synchronous and active-high. On a reset cycle, outputs become: ex_valid=0, ex_alu_op=BUBBLE_OP, ex_shamt=0, ex_alu_src_imm=0, ex_imm=0, ex_is_branch=0, ex_illegal=0.
- Decode is combinational from id_instr. All outputs are registered. Latency is 1 cycle from ID to EX.
- Decode table. op = instr[31:26], funct = instr[5:0].
  - op 000000, R-type, alu_src_imm=0:
    - funct 100000 or 100001 -> 010
    - funct 100010 or 100011 -> 110
    - funct 100100 -> 000
    - funct 100101 -> 001
    - funct 101010 -> 111
    - funct 000000 -> 100, shamt=instr[10:6]
    - funct 000010 -> 101, shamt=instr[10:6]
  - op 100011 (lw) or 101011 (sw) -> 010, imm sign-extended, alu_src_imm=1.
  - op 001000 (addi) -> 010, sign-extended, alu_src_imm=1.
  - op 001010 (slti) -> 111, sign-extended, alu_src_imm=1.
  - op 001100 (andi) -> 000, zero-extended, alu_src_imm=1.
  - op 001101 (ori) -> 001, zero-extended, alu_src_imm=1.
  - op 000100 (beq) -> 110, alu_src_imm=0, is_branch=1, imm sign-extended.
  - Anything else: op=ILLEGAL_OP, illegal=1, alu_src_imm=0, imm=0, shamt=0.
- Priority each cycle: reset > flush > stall > load.
  - flush: load bubble. ex_valid=0, ex_alu_op=BUBBLE_OP, all other outputs 0. Flush wins over a simultaneous stall.
  - stall (no flush): every output keeps its value.
  - load: ex_valid=id_valid and the other fields take the decoded values.
- When id_valid=0 on a load cycle, the register loads a bubble. ex_illegal is qualified: it is 1 only when id_valid=1.
- Instruction 0x00000000 (sll $0,$0,0) decodes as a valid SLL with shamt 0. It is not illegal.
- shamt is 0 for every non-shift instruction, including R-type instructions whose instr[10:6]≠0.
- Reset asserted mid-stall or mid-flush: reset values take effect on that edge. The first load can occur on the cycle after reset deasserts.
- No combinational path from any input to any output.

Test Plan:
- Reset: hold reset 2 cycles with id_valid=1, id_instr=0x00851020 -> ex_valid=0, ex_alu_op=010, all other outputs 0. After release, next edge -> ex_valid=1, ex_alu_op=010, alu_src_imm=0.
- Decode sweep, one instruction per cycle:
  - sub 0x00851022 -> 110
  - slt 0x0085102A -> 111
  - srl 0x00041082 -> 101, shamt=2
  - andi 0x3082FFFF -> 000, imm=0x0000FFFF
  - addi 0x2082FFFF -> 010, imm=0xFFFFFFFF
  - Each appears exactly 1 cycle later.
- Stall/flush: load lw 0x8C820004, then stall=1 for 3 cycles while id_instr changes -> outputs frozen (010, imm=4, alu_src_imm=1). Then stall=1 and flush=1 together -> ex_valid=0, ex_alu_op=010, imm=0.
- Branch and illegal:
  - beq 0x10850003 -> op=110, is_branch=1, imm=3.
  - opcode 111111 -> ex_illegal=1, op=000.
  - Same illegal word with id_valid=0 -> ex_illegal=0, ex_valid=0.
- Shamt masking: add with instr[10:6]=5'b10101 (0x00851560) -> ex_shamt=0, op=010.
- Reset during stall: stall=1 holding ori 0x34820F0F, assert reset for 1 cycle -> reset values on that edge. The next load decodes the new instruction normally.
